// File: rtl/fpnew_result_reorder.sv
// rtl/fpnew_result_reorder.sv - in-order retirement buffer for out-of-order opgroup results
module fpnew_result_reorder #(
   parameter int  Width    = 32,
   parameter int  Depth    = 4,
   parameter int  TagWidth = 4,
   localparam int IdWidth  = $clog2(Depth),
   localparam int CntWidth = $clog2(Depth + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                flush_i,
   input  logic                alloc_valid_i,
   output logic                alloc_ready_o,
   input  logic [TagWidth-1:0] alloc_tag_i,
   output logic [IdWidth-1:0]  alloc_id_o,
   input  logic                res_valid_i,
   output logic                res_ready_o,
   input  logic [IdWidth-1:0]  res_id_i,
   input  logic [Width-1:0]    res_result_i,
   input  logic [4:0]          res_status_i,
   input  logic                res_ext_bit_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [Width-1:0]    out_result_o,
   output logic [4:0]          out_status_o,
   output logic                out_ext_bit_o,
   output logic [TagWidth-1:0] out_tag_o,
   output logic [CntWidth-1:0] count_o,
   output logic                busy_o,
   output logic                err_o
);

   logic [Width-1:0]    result_q [Depth];
   logic [4:0]          status_q [Depth];
   logic                ext_q    [Depth];
   logic [TagWidth-1:0] tag_q    [Depth];
   logic [Depth-1:0]    alloc_q;
   logic [Depth-1:0]    done_q;
   logic [IdWidth-1:0]  head_q;
   logic [IdWidth-1:0]  tail_q;
   logic [CntWidth-1:0] count_q;
   logic                err_q;

   logic alloc_fire;
   logic out_fire;
   logic res_accept;
   logic res_illegal;

   // Allocation is decided from the current count only: a full buffer never
   // accepts, even if the head retires in the same cycle.
   assign alloc_ready_o = (count_q < CntWidth'(Depth));
   assign alloc_id_o    = tail_q;
   assign alloc_fire    = alloc_valid_i & alloc_ready_o;

   // A slot allocated this cycle is not yet marked, so a result for it is illegal.
   assign res_ready_o = 1'b1;
   assign res_accept  = res_valid_i & alloc_q[res_id_i] & ~done_q[res_id_i];
   assign res_illegal = res_valid_i & ~res_accept;

   // Outputs come from registered storage only, so capture-to-out is at least one cycle.
   assign out_valid_o   = alloc_q[head_q] & done_q[head_q];
   assign out_result_o  = result_q[head_q];
   assign out_status_o  = status_q[head_q];
   assign out_ext_bit_o = ext_q[head_q];
   assign out_tag_o     = tag_q[head_q];
   assign out_fire      = out_valid_o & out_ready_i;

   assign count_o = count_q;
   assign busy_o  = (count_q != '0);
   assign err_o   = err_q;

   // Slot state, pointers, occupancy and the error pulse; reset beats flush beats handshakes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) begin
            result_q[i] <= '0;
            status_q[i] <= '0;
            ext_q[i]    <= 1'b0;
            tag_q[i]    <= '0;
         end
         alloc_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else if (flush_i) begin
         alloc_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= res_illegal;
         // Capture, retire and allocate always touch distinct slots.
         if (res_accept) begin
            result_q[res_id_i] <= res_result_i;
            status_q[res_id_i] <= res_status_i;
            ext_q[res_id_i]    <= res_ext_bit_i;
            done_q[res_id_i]   <= 1'b1;
         end
         if (out_fire) begin
            alloc_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
            head_q          <= head_q + IdWidth'(1);
         end
         if (alloc_fire) begin
            alloc_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tag_q[tail_q]   <= alloc_tag_i;
            tail_q          <= tail_q + IdWidth'(1);
         end
         case ({alloc_fire, out_fire})
            2'b10:   count_q <= count_q + CntWidth'(1);
            2'b01:   count_q <= count_q - CntWidth'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: doc/fpnew_result_reorder.md
Name: fpnew_result_reorder

Overview:
- In-order retirement buffer at the output end of the opgroup blocks.
- The issue side reserves a slot in program order and receives a slot ID. It then dispatches the operation to any opgroup block, carrying that ID as its tag.
- Opgroup blocks return results out of order, each tagged with its slot ID.
- The buffer releases results to the writeback consumer strictly in allocation order, with valid/ready handshaking on every side.

Parameters:
- Width, 32, result datapath width in bits (matches FPU Width).
- Depth, 4, number of in-flight slots; power of two, at least 2.
- TagWidth, 4, width of the user tag stored per slot and returned on retirement.
- IdWidth, $clog2(Depth), localparam, slot ID width.
- CntWidth, $clog2(Depth+1), localparam, occupancy counter width.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all in-flight slots.
- alloc_valid_i  in  1  issue side requests a slot.
- alloc_ready_o  out  1  a free slot is available.
- alloc_tag_i  in  TagWidth  user tag stored in the allocated slot.
- alloc_id_o  out  IdWidth  ID of the slot the next allocation receives (tail pointer).
- res_valid_i  in  1  result from an opgroup block.
- res_ready_o  out  1  constant 1; results are never back-pressured.
- res_id_i  in  IdWidth  slot ID of the incoming result.
- res_result_i  in  Width  result value.
- res_status_i  in  5  fpnew_pkg::status_t flags.
- res_ext_bit_i  in  1  extension bit.
- out_valid_o  out  1  head slot is complete.
- out_ready_i  in  1  consumer accepts the head result.
- out_result_o  out  Width  head slot result.
- out_status_o  out  5  head slot status.
- out_ext_bit_o  out  1  head slot extension bit.
- out_tag_o  out  TagWidth  head slot user tag.
- count_o  out  CntWidth  number of allocated slots.
- busy_o  out  1  count_o != 0.
- err_o  out  1  one-cycle pulse when an illegal result is dropped.

Behaviour:

State:
- Storage is Depth entries of {result, status, ext_bit, tag, alloc, done}.
- head and tail pointers are IdWidth bits wide; count is CntWidth bits wide.

Reset (rst_i=1), evaluated in the same cycle's edge:
- All alloc/done bits, storage, head, tail and count go to 0.
- Resulting outputs: alloc_ready_o=1, alloc_id_o=0, out_valid_o=0, out_* data=0, count_o=0, busy_o=0, err_o=0.
- Reset overrides flush_i and every handshake in that cycle.

Flush (flush_i=1, rst_i=0):
- Clear all alloc/done bits; head=tail=0; count=0. Stored data is left as is.
- An alloc or result presented in the same cycle is ignored; err_o is not asserted.
- An out handshake in the same cycle is not counted as retired.

Allocation:
- alloc_ready_o = (count < Depth), decided combinationally from current count only. There is no bypass: a full buffer refuses alloc even when a retirement happens in the same cycle.
- On fire: slot[tail] gets alloc=1, done=0, tag=alloc_tag_i; tail = tail+1, modulo Depth (natural wrap).
- alloc_id_o = tail.

Result capture:
- Accepted when res_valid_i=1, slot[res_id_i].alloc=1 and slot[res_id_i].done=0.
- On accept: store result/status/ext_bit and set done=1.
- Illegal result (slot not allocated, or already done): the result is dropped, storage is unchanged, and err_o=1 in the next cycle for one cycle.
- A slot being allocated in the same cycle counts as not yet allocated, so a result for it in that cycle is illegal.

Retirement:
- out_valid_o = slot[head].alloc & slot[head].done. out_* data is read combinationally from slot[head].
- Minimum latency from result capture to out_valid_o is 1 cycle; there is no combinational path from res_* to out_*.
- On fire (out_valid_o & out_ready_i): clear alloc and done of slot[head]; head = head+1, modulo Depth.
- Once asserted, out_valid_o and out_* stay stable until the handshake completes or flush/reset occurs.

Count:
- +1 on alloc fire, -1 on out fire.
- Unchanged when both fire in the same cycle. This is legal at any non-full count, including count=0 only if a slot is already complete — which is impossible, so both firing implies count is at least 1.

Simultaneous events:
- Alloc, result capture and retirement may all occur in one cycle on different slots, and all take effect.
- A result and the retirement of the same slot cannot coincide, because retirement requires done=1, which makes that result illegal.

Test Plan:
- Reset, then allocate 4 slots with tags 0xA,0xB,0xC,0xD -> alloc_id_o reads 0,1,2,3; alloc_ready_o=0 after the 4th; count_o=4.
- Return results for IDs 3,1,0,2 (values 0x33,0x11,0x00,0x22) with out_ready_i=1 -> out stream is 0x00/tag A, 0x11/B, 0x22/C, 0x33/D, each appearing 1 cycle after its slot and all earlier slots are done; count_o ends at 0.
- Full buffer with head done and out_ready_i=1, plus alloc_valid_i=1 in the same cycle -> no alloc that cycle; alloc succeeds the next cycle with alloc_id_o=0 (wrap after 4 allocations).
- Result to an unallocated ID 2, then a duplicate result to done slot 0 -> each is dropped, err_o pulses for 1 cycle, and the stored value of slot 0 is unchanged.
- Hold out_ready_i=0 for 5 cycles with the head done -> out_valid_o and out_result_o stay stable; they release on the first cycle out_ready_i=1.
- Flush with 3 slots allocated and 1 done, plus res_valid_i in the same cycle -> next cycle count_o=0, out_valid_o=0, alloc_id_o=0, err_o=0; the next allocation gets ID 0. Repeat the sequence with rst_i instead of flush_i -> same outputs, and out_* data also reads 0.
